// File: rtl/axi_cdc_pwr_pkg.sv
// rtl/axi_cdc_pwr_pkg.sv - shared state type and count-width helper for the AXI CDC power controller
package axi_cdc_pwr_pkg;

  // Power sequencing states of the master-side domain
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } pwr_state_e;

  // Bits needed to hold a count from 0 up to and including max_count
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/axi_cdc_pwr_cnt.sv
// rtl/axi_cdc_pwr_cnt.sv - saturating outstanding-transaction counter with fault indication
module axi_cdc_pwr_cnt
  import axi_cdc_pwr_pkg::*;
#(
  parameter int MAX_COUNT = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            inc,
  input  logic                            dec,
  output logic [cnt_width(MAX_COUNT)-1:0] count,
  output logic                            fault
);

  localparam int W = cnt_width(MAX_COUNT);
  localparam logic [W-1:0] MAX_VAL = W'(MAX_COUNT);

  logic at_max;
  logic at_zero;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);

  // A lone increment at the ceiling or lone decrement at zero is refused and flagged;
  // the owner registers this into its sticky error so it lands on the same edge.
  assign fault = (inc & ~dec & at_max) | (dec & ~inc & at_zero);

  // Track outstanding transactions; simultaneous inc/dec cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + W'(1);
    end else if (dec && !inc && !at_zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/axi_cdc_pwr_ctrl.sv
// rtl/axi_cdc_pwr_ctrl.sv - AXI CDC master-side power controller; optional drain timeout via AXI_CDC_PWR_TIMEOUT_EN
module axi_cdc_pwr_ctrl
  import axi_cdc_pwr_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int WAKE_CYCLES     = 4,
  parameter int DRAIN_TIMEOUT   = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  aw_valid_i,
  input  logic                                  aw_ready_i,
  input  logic                                  ar_valid_i,
  input  logic                                  ar_ready_i,
  input  logic                                  b_valid_i,
  input  logic                                  b_ready_i,
  input  logic                                  r_valid_i,
  input  logic                                  r_ready_i,
  input  logic                                  r_last_i,
  input  logic                                  sleep_req_i,
  input  logic                                  incoming_req_i,
  output logic                                  isolate_o,
  output logic                                  clock_down_o,
  output logic                                  sleep_ack_o,
  output logic                                  wakeup_o,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0] wr_cnt_o,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0] rd_cnt_o,
`ifdef AXI_CDC_PWR_TIMEOUT_EN
  output logic                                  timeout_o,
`endif
  output logic                                  err_o
);

  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  pwr_state_e    state;
  logic [WW-1:0] wake_cnt;
  logic          wr_fault;
  logic          rd_fault;
  logic          incoming_q;
  logic          counts_idle;

`ifdef AXI_CDC_PWR_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  logic [DW-1:0] drain_cnt;
`endif

  axi_cdc_pwr_cnt #(.MAX_COUNT(MAX_OUTSTANDING)) u_wr_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (aw_valid_i & aw_ready_i),
    .dec   (b_valid_i & b_ready_i),
    .count (wr_cnt_o),
    .fault (wr_fault)
  );

  axi_cdc_pwr_cnt #(.MAX_COUNT(MAX_OUTSTANDING)) u_rd_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (ar_valid_i & ar_ready_i),
    .dec   (r_valid_i & r_ready_i & r_last_i),
    .count (rd_cnt_o),
    .fault (rd_fault)
  );

  // Drain decision looks at the registered counts, not this cycle's handshakes
  assign counts_idle = (wr_cnt_o == '0) && (rd_cnt_o == '0);

  // Sticky error flag and wakeup edge detector on the CDC incoming request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      incoming_q <= 1'b0;
      wakeup_o   <= 1'b0;
    end else begin
      err_o      <= err_o | wr_fault | rd_fault;
      incoming_q <= incoming_req_i;
      wakeup_o   <= (state == SLEEP) && incoming_req_i && !incoming_q;
    end
  end

  // Power sequencing FSM; outputs are loaded together with the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= RUN;
      wake_cnt     <= '0;
      isolate_o    <= 1'b0;
      clock_down_o <= 1'b0;
      sleep_ack_o  <= 1'b0;
`ifdef AXI_CDC_PWR_TIMEOUT_EN
      drain_cnt    <= '0;
      timeout_o    <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (sleep_req_i) begin
            state     <= DRAIN;
            isolate_o <= 1'b1;
`ifdef AXI_CDC_PWR_TIMEOUT_EN
            drain_cnt <= '0;
`endif
          end
        end
        DRAIN: begin
          if (!sleep_req_i) begin
            state    <= WAKE;
            wake_cnt <= '0;
          end else if (counts_idle) begin
            state        <= SLEEP;
            clock_down_o <= 1'b1;
            sleep_ack_o  <= 1'b1;
`ifdef AXI_CDC_PWR_TIMEOUT_EN
          end else if (drain_cnt == DRAIN_LAST) begin
            state        <= SLEEP;
            clock_down_o <= 1'b1;
            sleep_ack_o  <= 1'b1;
            timeout_o    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
`endif
          end
        end
        SLEEP: begin
          if (!sleep_req_i) begin
            state        <= WAKE;
            wake_cnt     <= '0;
            clock_down_o <= 1'b0;
            sleep_ack_o  <= 1'b0;
          end
        end
        WAKE: begin
          // Clock is back; hold isolation until it has settled, ignoring sleep_req_i
          if (wake_cnt == WAKE_LAST) begin
            state     <= RUN;
            isolate_o <= 1'b0;
          end else begin
            wake_cnt <= wake_cnt + WW'(1);
          end
        end
        default: begin
          state        <= RUN;
          isolate_o    <= 1'b0;
          clock_down_o <= 1'b0;
          sleep_ack_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_cdc_pwr_ctrl.md
AXI_CDC_PWR_CTRL -- requirements
Module: axi_cdc_pwr_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 8: maximum tracked outstanding transactions per direction.
REQ-002 The block SHALL have parameter WAKE_CYCLES, default 4: clock-settle cycles between clock_down_o release and isolate_o release.
REQ-003 The block SHALL have parameter DRAIN_TIMEOUT, default 1024: drain cycles before forced sleep; used only with AXI_CDC_PWR_TIMEOUT_EN.
REQ-004 The block SHALL have port clk_i, input, 1: the single clock.
REQ-005 The block SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have ports aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i, input, 1 each: snooped request handshakes on the master-side AXI port.
REQ-007 The block SHALL have ports b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i, input, 1 each: snooped response handshakes.
REQ-008 The block SHALL have port sleep_req_i, input, 1: level request to power down the master domain.
REQ-009 The block SHALL have port incoming_req_i, input, 1: the CDC incoming-request indication.
REQ-010 The block SHALL have ports isolate_o and clock_down_o, output, 1 each: drive the CDC master-side isolate and clock-down inputs.
REQ-011 The block SHALL have port sleep_ack_o, output, 1: high only in SLEEP.
REQ-012 The block SHALL have port wakeup_o, output, 1: one-cycle pulse on incoming_req_i seen in SLEEP.
REQ-013 The block SHALL have ports wr_cnt_o and rd_cnt_o, output, $clog2(MAX_OUTSTANDING+1) each: outstanding counts.
REQ-014 The block SHALL have port err_o, output, 1: sticky counter overflow/underflow flag.

Function
REQ-015 The write count SHALL increment on aw_valid_i&aw_ready_i and decrement on b_valid_i&b_ready_i, and SHALL hold when both occur in the same cycle.
REQ-016 The read count SHALL increment on ar_valid_i&ar_ready_i and decrement on r_valid_i&r_ready_i&r_last_i, and SHALL hold when both occur in the same cycle.
REQ-017 An increment at MAX_OUTSTANDING or a decrement at 0 SHALL leave the count unchanged and set err_o.
REQ-018 The FSM SHALL have states RUN, DRAIN, SLEEP and WAKE.
REQ-019 In RUN, outputs SHALL be isolate_o=0 and clock_down_o=0; sleep_req_i=1 SHALL move the FSM to DRAIN.
REQ-020 In DRAIN, outputs SHALL be isolate_o=1 and clock_down_o=0; both counts 0 (registered values) SHALL move the FSM to SLEEP; sleep_req_i=0 SHALL move it to WAKE.
REQ-021 In SLEEP, outputs SHALL be isolate_o=1, clock_down_o=1 and sleep_ack_o=1; sleep_req_i=0 SHALL move the FSM to WAKE.
REQ-022 incoming_req_i=1 in SLEEP SHALL pulse wakeup_o for exactly one cycle per rising edge, and SHALL NOT change state.
REQ-023 In WAKE, outputs SHALL be isolate_o=1 and clock_down_o=0; the FSM SHALL count WAKE_CYCLES cycles and then move to RUN.
REQ-024 sleep_req_i re-asserted during WAKE SHALL be ignored until RUN is reached.
REQ-025 All outputs SHALL be registered, so a state change is visible on outputs one cycle after the triggering input.
REQ-026 Counters SHALL keep tracking in every state.

Reset
REQ-027 When rst_i=1 at a clk_i edge: state SHALL become RUN and counts 0; isolate_o, clock_down_o, sleep_ack_o, wakeup_o and err_o SHALL be 0; the timeout counter SHALL be 0.
REQ-028 Reset asserted mid-DRAIN or mid-SLEEP SHALL abandon the sequence immediately, with no wake sequence.

Configuration
REQ-029 With AXI_CDC_PWR_TIMEOUT_EN defined, DRAIN SHALL count cycles and go to SLEEP after DRAIN_TIMEOUT cycles even if the counts are nonzero, and SHALL set sticky output timeout_o (1 bit; cleared only by reset).
REQ-030 Without AXI_CDC_PWR_TIMEOUT_EN, the timeout_o port and counter SHALL be absent, and DRAIN SHALL wait indefinitely.

Structure
REQ-031 Package axi_cdc_pwr_pkg SHALL hold the state enum pwr_state_e and the count-width function.
REQ-032 The outstanding counter SHALL be one sub-module, axi_cdc_pwr_cnt, instantiated twice (write, read).

Verification
REQ-033 Bench: 3 AW handshakes, then sleep_req_i=1, then 3 B responses -> isolate_o=1 one cycle after request; clock_down_o=1 one cycle after wr_cnt_o reaches 0.
REQ-034 Bench: AW and B handshakes in the same cycle with wr_cnt_o=2 -> wr_cnt_o stays 2, err_o=0.
REQ-035 Bench: B handshake with wr_cnt_o=0 -> wr_cnt_o=0, err_o=1 and stays 1 until rst_i.
REQ-036 Bench: in SLEEP, drop sleep_req_i with WAKE_CYCLES=4 -> clock_down_o=0 next cycle, isolate_o=0 exactly 4 cycles later, state RUN.
REQ-037 Bench: with macro, DRAIN_TIMEOUT=16 and rd_cnt_o stuck at 1 -> SLEEP entered after 16 drain cycles, timeout_o=1.
REQ-038 Bench: incoming_req_i held 5 cycles in SLEEP, then rst_i mid-SLEEP -> wakeup_o pulses once; after reset all outputs are 0 and state is RUN.
